// File: rtl/control_unit_seq_if.sv
// Bundle of instruction, control-strobe and memory-beat signals for control_unit_seq.
// The master side is upstream decode plus memory; the slave side is the control unit.
interface control_unit_seq_if #(
  parameter int LANES      = 16,
  parameter int BEAT_LANES = 4,
  parameter int ADDR_W     = 32
);
  localparam int NUM_BEATS = LANES / BEAT_LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic              instr_valid;
  logic [5:0]        Opcode;
  logic [2:0]        Func;
  logic [4:0]        Rd;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_ready;

  logic              PCSrc;
  logic              RegWrite;
  logic              RegWriteV;
  logic              MemtoReg;
  logic              MemWrite;
  logic              ALUSel;
  logic              Branch;
  logic              ALUSrc;
  logic              MemSrc;
  logic [2:0]        ALUControl;
  logic [1:0]        FlagWrite;
  logic [1:0]        ImmSrc;
  logic [1:0]        RegSrc;
  logic [1:0]        MemData;
  logic              Stuck;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] beat_idx;
  logic [LANES-1:0]  lane_mask;
  logic              instr_done;
  logic              illegal;

  modport master (
    output instr_valid, Opcode, Func, Rd, base_addr, mem_ready,
    input  PCSrc, RegWrite, RegWriteV, MemtoReg, MemWrite, ALUSel, Branch, ALUSrc, MemSrc,
    input  ALUControl, FlagWrite, ImmSrc, RegSrc, MemData,
    input  Stuck, mem_req, mem_addr, beat_idx, lane_mask, instr_done, illegal
  );

  modport slave (
    input  instr_valid, Opcode, Func, Rd, base_addr, mem_ready,
    output PCSrc, RegWrite, RegWriteV, MemtoReg, MemWrite, ALUSel, Branch, ALUSrc, MemSrc,
    output ALUControl, FlagWrite, ImmSrc, RegSrc, MemData,
    output Stuck, mem_req, mem_addr, beat_idx, lane_mask, instr_done, illegal
  );
endinterface

// File: rtl/control_unit_seq.sv
// Sequencing control unit for the SIMD AES core: registered decode plus a beat engine
// that splits vector loads/stores into NUM_BEATS memory beats and stalls upstream meanwhile.
module control_unit_seq #(
  parameter int LANES      = 16,
  parameter int BEAT_LANES = 4,
  parameter int ADDR_W     = 32
) (
  input logic               clk,
  input logic               rst_n,
  control_unit_seq_if.slave cu_if
);

  localparam int NUM_BEATS = LANES / BEAT_LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  localparam logic [5:0] OP_ALU    = 6'b000000;
  localparam logic [5:0] OP_VALU   = 6'b100000;
  localparam logic [5:0] OP_BRANCH = 6'b001100;
  localparam logic [5:0] OP_LDR    = 6'b011001;
  localparam logic [5:0] OP_STR    = 6'b011000;
  localparam logic [5:0] OP_VLDR   = 6'b111001;
  localparam logic [5:0] OP_VSTR   = 6'b111000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       regwritev;
    logic       memtoreg;
    logic       memwrite;
    logic       alusel;
    logic       branch;
    logic       alusrc;
    logic       memsrc;
    logic [2:0] alucontrol;
    logic [1:0] flagwrite;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] memdata;
    logic       stuck;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // Single-cycle decode for everything except vector memory ops.
  function automatic ctrl_t decode_exec(input logic [5:0] op, input logic [2:0] func);
    ctrl_t c;
    c = '0;
    c.instr_done = 1'b1;
    case (op)
      OP_ALU: begin
        c.regwrite   = 1'b1;
        c.alucontrol = func;
      end
      OP_VALU: begin
        c.regwritev  = 1'b1;
        c.alusel     = 1'b1;
        c.alucontrol = func;
      end
      OP_BRANCH: begin
        c.branch     = 1'b1;
        c.pcsrc      = 1'b1;
        c.alucontrol = 3'b001;
        c.flagwrite  = 2'b01;
      end
      OP_LDR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
      end
      OP_STR: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
      end
      default: begin
        c.instr_done = 1'b0;
        c.illegal    = 1'b1;
      end
    endcase
    return c;
  endfunction

  // Register-write strobes stay low while beats are moving; the load writes back in WB.
  function automatic ctrl_t mem_ctrl(input logic store);
    ctrl_t c;
    c = '0;
    c.stuck    = 1'b1;
    c.alusrc   = 1'b1;
    c.memdata  = 2'b01;
    c.memwrite = store;
    c.memsrc   = store;
    return c;
  endfunction

  function automatic ctrl_t wb_ctrl(input logic store);
    ctrl_t c;
    c = '0;
    c.instr_done = 1'b1;
    c.regwritev  = !store;
    c.memtoreg   = !store;
    return c;
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] beat);
    return base + ADDR_W'(beat) * ADDR_W'(BEAT_LANES);
  endfunction

  function automatic logic [LANES-1:0] beat_mask(input logic [BEAT_W-1:0] beat);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) begin
      m[i] = ((i / BEAT_LANES) == int'(beat));
    end
    return m;
  endfunction

  function automatic logic is_vmem(input logic [5:0] op);
    return (op == OP_VLDR) || (op == OP_VSTR);
  endfunction

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] base_q;
  logic              accept;

  assign accept = cu_if.instr_valid && (state_q != S_MEM);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ctrl_d  = '0;
    req_d   = 1'b0;
    addr_d  = '0;
    mask_d  = '0;
    store_d = store_q;
    case (state_q)
      S_MEM: begin
        ctrl_d = mem_ctrl(store_q);
        req_d  = 1'b1;
        addr_d = addr_q;
        mask_d = mask_q;
        if (cu_if.mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_WB;
            ctrl_d  = wb_ctrl(store_q);
            req_d   = 1'b0;
            addr_d  = '0;
            mask_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            addr_d = beat_addr(base_q, beat_q + BEAT_W'(1));
            mask_d = beat_mask(beat_q + BEAT_W'(1));
          end
        end
      end
      default: begin
        if (accept) begin
          store_d = (cu_if.Opcode == OP_VSTR);
          if (is_vmem(cu_if.Opcode)) begin
            state_d = S_MEM;
            beat_d  = '0;
            ctrl_d  = mem_ctrl(cu_if.Opcode == OP_VSTR);
            req_d   = 1'b1;
            addr_d  = cu_if.base_addr;
            mask_d  = beat_mask('0);
          end else begin
            state_d = S_EXEC;
            ctrl_d  = decode_exec(cu_if.Opcode, cu_if.Func);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Stage boundary: all control outputs are registered; async reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      ctrl_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ctrl_q  <= ctrl_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      store_q <= store_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      base_q <= cu_if.base_addr;
    end
  end

  assign cu_if.PCSrc      = ctrl_q.pcsrc;
  assign cu_if.RegWrite   = ctrl_q.regwrite;
  assign cu_if.RegWriteV  = ctrl_q.regwritev;
  assign cu_if.MemtoReg   = ctrl_q.memtoreg;
  assign cu_if.MemWrite   = ctrl_q.memwrite;
  assign cu_if.ALUSel     = ctrl_q.alusel;
  assign cu_if.Branch     = ctrl_q.branch;
  assign cu_if.ALUSrc     = ctrl_q.alusrc;
  assign cu_if.MemSrc     = ctrl_q.memsrc;
  assign cu_if.ALUControl = ctrl_q.alucontrol;
  assign cu_if.FlagWrite  = ctrl_q.flagwrite;
  assign cu_if.ImmSrc     = ctrl_q.immsrc;
  assign cu_if.RegSrc     = ctrl_q.regsrc;
  assign cu_if.MemData    = ctrl_q.memdata;
  assign cu_if.Stuck      = ctrl_q.stuck;
  assign cu_if.instr_done = ctrl_q.instr_done;
  assign cu_if.illegal    = ctrl_q.illegal;
  assign cu_if.mem_req    = req_q;
  assign cu_if.mem_addr   = addr_q;
  assign cu_if.beat_idx   = beat_q;
  assign cu_if.lane_mask  = mask_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Randomised bench for control_unit_seq: a per-cycle reference of the decode table and
// beat sequencing, driven one instruction at a time with optional memory stalls.
module tb_control_unit_seq;

  localparam int LANES = 16;
  localparam int BL    = 4;
  localparam int AW    = 32;
  localparam int NB    = LANES / BL;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

  typedef struct packed {
    logic          pcsrc;
    logic          regwrite;
    logic          regwritev;
    logic          memtoreg;
    logic          memwrite;
    logic          alusel;
    logic          branch;
    logic          alusrc;
    logic          memsrc;
    logic [2:0]    alucontrol;
    logic [1:0]    flagwrite;
    logic [1:0]    immsrc;
    logic [1:0]    regsrc;
    logic [1:0]    memdata;
    logic          stuck;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] beat_idx;
    logic [LANES-1:0] lane_mask;
    logic          instr_done;
    logic          illegal;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  control_unit_seq_if #(.LANES(LANES), .BEAT_LANES(BL), .ADDR_W(AW)) bus ();

  control_unit_seq #(.LANES(LANES), .BEAT_LANES(BL), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t obs();
    exp_t o;
    o.pcsrc      = bus.PCSrc;
    o.regwrite   = bus.RegWrite;
    o.regwritev  = bus.RegWriteV;
    o.memtoreg   = bus.MemtoReg;
    o.memwrite   = bus.MemWrite;
    o.alusel     = bus.ALUSel;
    o.branch     = bus.Branch;
    o.alusrc     = bus.ALUSrc;
    o.memsrc     = bus.MemSrc;
    o.alucontrol = bus.ALUControl;
    o.flagwrite  = bus.FlagWrite;
    o.immsrc     = bus.ImmSrc;
    o.regsrc     = bus.RegSrc;
    o.memdata    = bus.MemData;
    o.stuck      = bus.Stuck;
    o.mem_req    = bus.mem_req;
    o.mem_addr   = bus.mem_addr;
    o.beat_idx   = bus.beat_idx;
    o.lane_mask  = bus.lane_mask;
    o.instr_done = bus.instr_done;
    o.illegal    = bus.illegal;
    return o;
  endfunction

  // Outputs one cycle after accepting a non-vector-memory instruction.
  function automatic exp_t model_exec(input logic [5:0] op, input logic [2:0] func);
    exp_t e;
    e = '0;
    if (op == 6'b000000) begin
      e.regwrite = 1; e.alucontrol = func; e.instr_done = 1;
    end else if (op == 6'b100000) begin
      e.regwritev = 1; e.alusel = 1; e.alucontrol = func; e.instr_done = 1;
    end else if (op == 6'b001100) begin
      e.branch = 1; e.pcsrc = 1; e.alucontrol = 3'b001; e.flagwrite = 2'b01; e.instr_done = 1;
    end else if (op == 6'b011001) begin
      e.regwrite = 1; e.memtoreg = 1; e.alusrc = 1; e.instr_done = 1;
    end else if (op == 6'b011000) begin
      e.memwrite = 1; e.alusrc = 1; e.instr_done = 1;
    end else begin
      e.illegal = 1;
    end
    return e;
  endfunction

  function automatic exp_t model_beat(input logic [AW-1:0] base, input int k, input bit store);
    exp_t e;
    longint unsigned ones;
    e = '0;
    ones        = (64'd1 << BL) - 64'd1;
    e.stuck     = 1;
    e.mem_req   = 1;
    e.mem_addr  = base + AW'(k * BL);
    e.beat_idx  = BW'(k);
    e.lane_mask = LANES'(ones << (k * BL));
    e.memwrite  = store;
    e.memsrc    = store;
    return e;
  endfunction

  function automatic exp_t care_beat();
    exp_t c;
    c = '0;
    c.stuck = '1; c.mem_req = '1; c.mem_addr = '1; c.beat_idx = '1; c.lane_mask = '1;
    c.memwrite = '1; c.memsrc = '1; c.regwrite = '1; c.regwritev = '1;
    c.instr_done = '1; c.illegal = '1; c.branch = '1; c.pcsrc = '1;
    return c;
  endfunction

  function automatic exp_t model_wb(input bit store);
    exp_t e;
    e = '0;
    e.instr_done = 1;
    e.regwritev  = !store;
    e.memtoreg   = !store;
    return e;
  endfunction

  function automatic exp_t care_wb();
    exp_t c;
    c = '0;
    c.stuck = '1; c.mem_req = '1; c.instr_done = '1; c.regwritev = '1;
    c.memtoreg = '1; c.regwrite = '1; c.memwrite = '1; c.illegal = '1;
    return c;
  endfunction

  // Issues one instruction and checks every following cycle until it completes.
  task automatic run_instr(input logic [5:0] op, input logic [2:0] func, input logic [AW-1:0] base,
                           input int stall_beat, input int stall_len, input int stall_pct,
                           input string name, output int stuck_seen);
    exp_t e, o, c;
    int   k, held, cyc;
    bit   rdy, vmem, store;
    vmem = (op == 6'b111001) || (op == 6'b111000);
    store = (op == 6'b111000);
    stuck_seen = 0;
    bus.instr_valid = 1'b1;
    bus.Opcode      = op;
    bus.Func        = func;
    bus.Rd          = 5'($urandom);
    bus.base_addr   = base;
    bus.mem_ready   = 1'($urandom);
    tick();
    bus.instr_valid = 1'b0;
    bus.Opcode      = 6'($urandom);
    bus.Func        = 3'($urandom);
    bus.base_addr   = $urandom;
    if (!vmem) begin
      o = obs();
      e = model_exec(op, func);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s exec: got %h expected %h", name, o, e);
      end
    end else begin
      k = 0; held = 0; cyc = 0;
      c = care_beat();
      while (k < NB && cyc < 64) begin
        o = obs();
        e = model_beat(base, k, store);
        stuck_seen += int'(o.stuck);
        tests_run++;
        if ((o & c) !== (e & c)) begin
          tests_failed++;
          $display("FAIL %s beat%0d: got %h expected %h", name, k, o & c, e & c);
        end
        if (stall_pct > 0) rdy = (cyc >= 40) || ($urandom_range(99) >= stall_pct);
        else if (k == stall_beat && held < stall_len) begin rdy = 0; held++; end
        else rdy = 1;
        bus.mem_ready   = rdy;
        bus.instr_valid = 1'($urandom_range(1));
        bus.Opcode      = 6'($urandom);
        tick();
        bus.instr_valid = 1'b0;
        if (rdy) k++;
        cyc++;
      end
      o = obs();
      e = model_wb(store);
      c = care_wb();
      stuck_seen += int'(o.stuck);
      tests_run++;
      if ((o & c) !== (e & c)) begin
        tests_failed++;
        $display("FAIL %s wb: got %h expected %h", name, o & c, e & c);
      end
    end
  endtask

  task automatic check_idle(input string name);
    exp_t o;
    bus.instr_valid = 1'b0;
    tick();
    o = obs();
    tests_run++;
    if (o !== exp_t'('0)) begin
      tests_failed++;
      $display("FAIL %s idle: got %h expected 0", name, o);
    end
  endtask

  task automatic test_reset();
    exp_t o;
    int   s;
    rst_n = 1'b0;
    bus.instr_valid = 1'b1; bus.Opcode = 6'b000000; bus.Func = 3'b011;
    bus.Rd = '0; bus.base_addr = '0; bus.mem_ready = 1'b1;
    repeat (3) tick();
    o = obs();
    tests_run++;
    if (o !== exp_t'('0)) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", o);
    end
    rst_n = 1'b1;
    run_instr(6'b000000, 3'b011, 32'h0, 0, 0, 0, "reset_first_alu", s);
  endtask

  task automatic test_branch();
    int s;
    run_instr(6'b001100, 3'($urandom), $urandom, 0, 0, 0, "branch", s);
    check_idle("branch_after");
  endtask

  task automatic test_vload();
    int s;
    bus.mem_ready = 1'b1;
    run_instr(6'b111001, 3'b000, 32'h100, 0, 0, 0, "vload", s);
    tests_run++;
    if (s != NB) begin
      tests_failed++;
      $display("FAIL vload_stuck_cycles: got %0d expected %0d", s, NB);
    end
    check_idle("vload_after");
  endtask

  task automatic test_vstore_stall();
    int s;
    run_instr(6'b111000, 3'b000, 32'h0000_2000, 2, 3, 0, "vstore_stall", s);
    tests_run++;
    if (s != NB + 3) begin
      tests_failed++;
      $display("FAIL vstore_stuck_cycles: got %0d expected %0d", s, NB + 3);
    end
    check_idle("vstore_after");
  endtask

  task automatic test_illegal();
    int s;
    run_instr(6'b111111, 3'($urandom), $urandom, 0, 0, 0, "illegal", s);
    check_idle("illegal_after");
  endtask

  task automatic test_reset_mid_mem();
    exp_t o, e, c;
    int   s;
    c = care_beat();
    bus.instr_valid = 1'b1; bus.Opcode = 6'b111001; bus.base_addr = 32'h200; bus.mem_ready = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    o = obs();
    e = model_beat(32'h200, 1, 1'b0);
    tests_run++;
    if ((o & c) !== (e & c)) begin
      tests_failed++;
      $display("FAIL rst_mid_beat1: got %h expected %h", o & c, e & c);
    end
    #2 rst_n = 1'b0;
    #1;
    o = obs();
    tests_run++;
    if (o !== exp_t'('0)) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got %h expected 0", o);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    check_idle("rst_mid_no_wb");
    run_instr(6'b000000, 3'b000, 32'h0, 0, 0, 0, "rst_mid_alu_after", s);
  endtask

  task automatic test_back_to_back();
    int s;
    logic [5:0] scalar_ops [5];
    scalar_ops = '{6'b000000, 6'b100000, 6'b001100, 6'b011001, 6'b011000};
    for (int i = 0; i < 6; i++) begin
      run_instr(scalar_ops[$urandom_range(4)], 3'($urandom), $urandom, 0, 0, 0, "b2b_scalar", s);
    end
    run_instr(6'b111001, 3'b000, $urandom, 0, 0, 0, "b2b_vload", s);
    run_instr(6'b100000, 3'b101, $urandom, 0, 0, 0, "b2b_after_wb", s);
    run_instr(6'b111000, 3'b000, $urandom, 1, 2, 0, "b2b_vstore", s);
    run_instr(6'b111001, 3'b000, $urandom, 0, 0, 0, "b2b_vload2", s);
    check_idle("b2b_after");
  endtask

  task automatic test_random();
    int s;
    logic [5:0] op;
    logic [5:0] legal [7];
    logic [5:0] bad [4];
    legal = '{6'b000000, 6'b100000, 6'b001100, 6'b011001, 6'b011000, 6'b111001, 6'b111000};
    bad   = '{6'b111111, 6'b010101, 6'b000001, 6'b101001};
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7) == 0) op = bad[$urandom_range(3)];
      else op = legal[$urandom_range(6)];
      run_instr(op, 3'($urandom), $urandom, 0, 0, 30, "random", s);
      if ($urandom_range(1) == 1) check_idle("random_gap");
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_branch();
    test_vload();
    test_vstore_stall();
    test_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit_seq.md
Name: control_unit_seq

Overview:
- Parametrised, sequencing successor to the single-cycle control unit of the SIMD AES core.
- Decodes Opcode/Func/Rd into the same control-signal set.
- Registers decode results so outputs are valid one cycle after acceptance.
- Splits vector loads/stores into NUM_BEATS memory beats with a ready handshake, driving Stuck to stall fetch/decode while a multi-beat access is in flight.

Parameters:
LANES, 16, vector lanes per vector register (AES state = 16 bytes)
BEAT_LANES, 4, lanes moved per memory beat; must divide LANES; NUM_BEATS = LANES/BEAT_LANES
ADDR_W, 32, memory address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  decoded-stage instruction present
Opcode  in  6  instruction opcode; bit 5 = vector
Func  in  3  ALU function
Rd  in  5  destination register
base_addr  in  ADDR_W  effective base address for loads/stores
mem_ready  in  1  memory accepts/returns current beat
PCSrc, RegWrite, RegWriteV, MemtoReg, MemWrite, ALUSel, Branch, ALUSrc, MemSrc  out  1 each  control strobes
ALUControl  out  3  ALU operation
FlagWrite, ImmSrc, RegSrc, MemData  out  2 each  control selects
Stuck  out  1  stall request to upstream stages
mem_req  out  1  beat request valid
mem_addr  out  ADDR_W  beat address
beat_idx  out  $clog2(NUM_BEATS) (min 1)  current beat number
lane_mask  out  LANES  one-hot-group mask of lanes in current beat
instr_done  out  1  one-cycle pulse when an instruction completes
illegal  out  1  one-cycle pulse for undefined opcode

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE; beat counter=0; all outputs 0, including Stuck, mem_req, instr_done and illegal.
- FSM states: IDLE, EXEC, MEM, WB.
- Acceptance: instr_valid && state!=MEM. Opcode, Func, Rd and base_addr are latched on the accepting edge.
- Next state after acceptance: MEM if vector load/store, otherwise EXEC. With no acceptance, EXEC/WB return to IDLE. Back-to-back acceptance in EXEC/WB is legal.
- Decode table (applied to the latched instruction):
  - 000000 scalar ALU: RegWrite=1, ALUControl=Func.
  - 100000 vector ALU: RegWriteV=1, ALUSel=1, ALUControl=Func.
  - 001100 branch: Branch=1, PCSrc=1, ALUControl=001, FlagWrite=01.
  - 011001 scalar load: RegWrite=1, MemtoReg=1, ALUSrc=1.
  - 011000 scalar store: MemWrite=1, ALUSrc=1.
  - 111001 vector load: RegWriteV=1, MemtoReg=1, ALUSrc=1, MemData=01.
  - 111000 vector store: MemWrite=1, MemSrc=1, ALUSrc=1, MemData=01.
  - Any other opcode: all strobes 0, illegal=1 for one cycle, Stuck=0, instr_done=0.
- EXEC: decoded outputs valid for exactly 1 cycle; instr_done=1.
- MEM:
  - Stuck=1.
  - mem_req=1.
  - mem_addr = latched base + beat_idx*BEAT_LANES.
  - lane_mask has bits [beat_idx*BEAT_LANES +: BEAT_LANES] set.
  - Store only: MemWrite=MemSrc=1 throughout.
  - Register-write strobes are held 0.
- Beat handshake: a beat completes on a cycle with mem_req && mem_ready. The counter increments; with mem_ready=0 it holds and address/mask stay stable.
- Last beat completion (beat_idx==NUM_BEATS-1 && mem_ready): counter wraps to 0 and FSM goes to WB.
- WB: Stuck=0; instr_done=1. Load additionally asserts RegWriteV=1 and MemtoReg=1 for that cycle only.
- Latency:
  - Non-memory-vector ops: outputs 1 cycle after acceptance.
  - Vector load/store: 1 + NUM_BEATS + (stall cycles) until WB.
- instr_valid while in MEM is ignored; upstream holds it because Stuck=1.
- Reset asserted mid-MEM aborts the transfer: mem_req/Stuck drop immediately (async) and no WB occurs.

Test Plan:
- Reset with instr_valid=1, Opcode=000000 → all outputs 0. Release and accept, Func=011 → next cycle RegWrite=1, ALUControl=011, instr_done=1, Stuck=0.
- Opcode=001100 → 1 cycle later Branch=1, PCSrc=1, ALUControl=001, FlagWrite=01; following idle cycle all 0.
- Vector load 111001, base_addr=0x100, mem_ready=1 constantly (defaults) → Stuck=1 for 4 cycles, mem_addr 0x100,0x104,0x108,0x10C, lane_mask 0x000F,0x00F0,0x0F00,0xF000; then WB with RegWriteV=1, instr_done=1, Stuck=0.
- Vector store 111000 with mem_ready low on beat 2 for 3 cycles → mem_addr/beat_idx held at beat 2, MemWrite=MemSrc=1 throughout MEM, Stuck lasts 7 cycles, no RegWriteV.
- Opcode=111111 → illegal=1 one cycle, Stuck=0, no write strobes, instr_done=0.
- rst_n pulled low during beat 1 of vector load → mem_req/Stuck 0 immediately, no RegWriteV; after release a scalar add completes normally.
